// File: rtl/mem_access_unit.sv
// MEM-stage load/store initiator: byte/half/word loads with extension, sub-word stores by read-modify-write.
// Optional MISALIGN_TRAP_EN: fault misaligned half/word accesses instead of ignoring the low address bits.
module mem_access_unit #(
  parameter int          MEM_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_we,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  state_t      state;
  logic        we_q;
  logic        uns_q;
  logic [1:0]  size_q;
  logic [1:0]  lane_q;
  logic [31:0] wdata_q;

  logic [31:0] off;
  logic [31:0] idx;
  logic        bad_addr;
  logic        misalign;
  logic        req_err;

  assign off      = req_addr - BASE_ADDR;
  assign idx      = off >> 2;
  assign bad_addr = (req_addr < BASE_ADDR) || (idx >= 32'(MEM_WORDS));

`ifdef MISALIGN_TRAP_EN
  assign misalign = ((req_size == 2'b01) && req_addr[0]) ||
                    ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  assign req_err = (req_size == 2'b11) || bad_addr || misalign;

  // Half accesses only look at lane bit 1 and words at lane 0, so untrapped misalignment is ignored.
  function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] size,
                                               input logic [1:0] lane, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{lane, 3'b000} +: 8];
    h = word[{lane[1], 4'b0000} +: 16];
    case (size)
      2'b00:   load_extract = {{24{~uns & b[7]}}, b};
      2'b01:   load_extract = {{16{~uns & h[15]}}, h};
      default: load_extract = word;
    endcase
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] word, input logic [31:0] wdata,
                                              input logic [1:0] size, input logic [1:0] lane);
    store_merge = word;
    case (size)
      2'b00:   store_merge[{lane, 3'b000} +: 8]     = wdata[7:0];
      2'b01:   store_merge[{lane[1], 4'b0000} +: 16] = wdata[15:0];
      default: store_merge = wdata;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'h0;
      rsp_err   <= 1'b0;
      mem_we    <= 1'b0;
      mem_a     <= 32'h0;
      mem_wd    <= 32'h0;
      we_q      <= 1'b0;
      uns_q     <= 1'b0;
      size_q    <= 2'b00;
      lane_q    <= 2'b00;
      wdata_q   <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            we_q      <= req_we;
            uns_q     <= req_unsigned;
            size_q    <= req_size;
            lane_q    <= req_addr[1:0];
            wdata_q   <= req_wdata;
            mem_a     <= idx;
            if (req_err) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= 32'h0;
            end else if (req_we && (req_size == 2'b10)) begin
              state  <= WRITE;
              mem_we <= 1'b1;
              mem_wd <= req_wdata;
            end else begin
              state <= READ;
            end
          end
        end
        // The combinational read is captured here, either as the load result or as the merge base.
        READ: begin
          if (we_q) begin
            state  <= WRITE;
            mem_we <= 1'b1;
            mem_wd <= store_merge(mem_rd, wdata_q, size_q, lane_q);
          end else begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_rdata <= load_extract(mem_rd, size_q, lane_q, uns_q);
          end
        end
        WRITE: begin
          state     <= RESP;
          mem_we    <= 1'b0;
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b0;
          rsp_rdata <= 32'h0;
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed requests with a queue of expected responses
// and a behavioural single-port memory.
module tb_mem_access_unit;

  localparam int MEM_WORDS = 1024;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_we;
  logic [31:0] mem_a;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          lat;
  } exp_t;

  exp_t        expQ[$];
  logic [31:0] mem [0:MEM_WORDS-1];
  int          weCount = 0;
  logic [31:0] lastWeAddr = 32'h0;
  int          nAsserts = 0;
  int          nFail = 0;
  int          weBefore;

  mem_access_unit #(.MEM_WORDS(MEM_WORDS), .BASE_ADDR(32'h0)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: combinational read, write on the rising edge.
  assign mem_rd = (mem_a < 32'(MEM_WORDS)) ? mem[mem_a[9:0]] : 32'h0;

  always @(posedge clk) begin
    if (mem_we) begin
      if (mem_a < 32'(MEM_WORDS)) mem[mem_a[9:0]] <= mem_wd;
      weCount    <= weCount + 1;
      lastWeAddr <= mem_a;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    nAsserts++;
    assert (obs === expv) else begin
      nFail++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Drives one request, returns just after its accept edge with the expectation queued.
  task automatic applyStimulus(input logic we, input logic [1:0] size, input logic uns,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [31:0] expData, input logic expErr, input int expLat);
    int w;
    exp_t e;
    @(negedge clk);
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
    w = 0;
    while (!req_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    check("req_ready_before_accept", {31'b0, req_ready}, 32'h1);
    @(posedge clk);
    e.data = expData;
    e.err  = expErr;
    e.lat  = expLat;
    expQ.push_back(e);
    #1;
    req_valid = 1'b0;
  endtask

  // Waits (bounded) for the response, compares against the queue head, optionally stalls, then consumes.
  task automatic checkOutput(input string tag, input int holdCycles);
    exp_t e;
    int   lat;
    if (expQ.size() == 0) begin
      check({tag, "_queue_empty"}, 32'h0, 32'h1);
      return;
    end
    e = expQ.pop_front();
    lat = 0;
    while (lat < 10) begin
      @(negedge clk);
      lat++;
      if (rsp_valid) break;
    end
    check({tag, "_latency"}, lat, e.lat);
    check({tag, "_rdata"}, rsp_rdata, e.data);
    check({tag, "_err"}, {31'b0, rsp_err}, {31'b0, e.err});
    for (int i = 0; i < holdCycles; i++) begin
      @(negedge clk);
      check({tag, "_hold_valid"}, {31'b0, rsp_valid}, 32'h1);
      check({tag, "_hold_rdata"}, rsp_rdata, e.data);
      check({tag, "_hold_req_ready"}, {31'b0, req_ready}, 32'h0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    check({tag, "_consumed"}, {30'b0, rsp_valid, req_ready}, 32'h1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin
    rst          = 1'b0;
    req_valid    = 1'b0;
    req_we       = 1'b0;
    req_size     = 2'b00;
    req_unsigned = 1'b0;
    req_addr     = 32'h0;
    req_wdata    = 32'h0;
    rsp_ready    = 1'b0;
    #12;
    check("reset_req_ready", {31'b0, req_ready}, 32'h1);
    check("reset_rsp_valid", {31'b0, rsp_valid}, 32'h0);
    check("reset_rsp_rdata", rsp_rdata, 32'h0);
    check("reset_rsp_err", {31'b0, rsp_err}, 32'h0);
    check("reset_mem_we", {31'b0, mem_we}, 32'h0);
    check("reset_mem_a", mem_a, 32'h0);
    check("reset_mem_wd", mem_wd, 32'h0);
    @(negedge clk);
    rst = 1'b1;

    // Reset in the middle of a word store drops the write.
    applyStimulus(1'b1, 2'b10, 1'b0, 32'h10, 32'h11111111, 32'h0, 1'b0, 2);
    checkOutput("prefill_w4", 0);
    applyStimulus(1'b1, 2'b10, 1'b0, 32'h10, 32'h22222222, 32'h0, 1'b0, 2);
    check("midwrite_mem_we_high", {31'b0, mem_we}, 32'h1);
    #2;
    rst = 1'b0;
    #1;
    check("midreset_mem_we", {31'b0, mem_we}, 32'h0);
    check("midreset_req_ready", {31'b0, req_ready}, 32'h1);
    check("midreset_rsp_valid", {31'b0, rsp_valid}, 32'h0);
    expQ.delete();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midreset_mem4_unchanged", mem[4], 32'h11111111);

    // Word store then word load.
    weBefore = weCount;
    applyStimulus(1'b1, 2'b10, 1'b0, 32'h8, 32'hDEADBEEF, 32'h0, 1'b0, 2);
    checkOutput("store_word_8", 0);
    check("store_word_we_pulses", weCount - weBefore, 1);
    check("store_word_mem_a", lastWeAddr, 32'h2);
    check("store_word_mem2", mem[2], 32'hDEADBEEF);
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h8, 32'h0, 32'hDEADBEEF, 1'b0, 2);
    checkOutput("load_word_8", 0);

    // Byte store merge and signed/unsigned byte loads.
    applyStimulus(1'b1, 2'b10, 1'b0, 32'h4, 32'h00000006, 32'h0, 1'b0, 2);
    checkOutput("store_word_4", 0);
    weBefore = weCount;
    applyStimulus(1'b1, 2'b00, 1'b0, 32'h5, 32'hFFFFFF80, 32'h0, 1'b0, 3);
    checkOutput("store_byte_5", 0);
    check("store_byte_we_pulses", weCount - weBefore, 1);
    check("store_byte_mem1", mem[1], 32'h00008006);
    applyStimulus(1'b0, 2'b00, 1'b0, 32'h5, 32'h0, 32'hFFFFFF80, 1'b0, 2);
    checkOutput("load_byte_s_5", 0);
    applyStimulus(1'b0, 2'b00, 1'b1, 32'h5, 32'h0, 32'h00000080, 1'b0, 2);
    checkOutput("load_byte_u_5", 0);
    applyStimulus(1'b0, 2'b00, 1'b1, 32'h4, 32'h0, 32'h00000006, 1'b0, 2);
    checkOutput("load_byte_u_4", 0);

    // Half store into the upper lane and signed half load.
    applyStimulus(1'b1, 2'b01, 1'b0, 32'h6, 32'h0000A5A5, 32'h0, 1'b0, 3);
    checkOutput("store_half_6", 0);
    check("store_half_mem1", mem[1], 32'hA5A58006);
    applyStimulus(1'b0, 2'b01, 1'b0, 32'h6, 32'h0, 32'hFFFFA5A5, 1'b0, 2);
    checkOutput("load_half_s_6", 0);
    applyStimulus(1'b0, 2'b01, 1'b1, 32'h4, 32'h0, 32'h00008006, 1'b0, 2);
    checkOutput("load_half_u_4", 0);

    // Out-of-range and reserved-size requests fault without touching memory.
    weBefore = weCount;
    applyStimulus(1'b0, 2'b10, 1'b0, 32'(4 * MEM_WORDS), 32'h0, 32'h0, 1'b1, 1);
    checkOutput("load_oor", 0);
    applyStimulus(1'b1, 2'b10, 1'b0, 32'(4 * MEM_WORDS), 32'h12345678, 32'h0, 1'b1, 1);
    checkOutput("store_oor", 0);
    applyStimulus(1'b1, 2'b11, 1'b0, 32'h0, 32'h12345678, 32'h0, 1'b1, 1);
    checkOutput("store_size11", 0);
    applyStimulus(1'b0, 2'b11, 1'b0, 32'h8, 32'h0, 32'h0, 1'b1, 1);
    checkOutput("load_size11", 0);
    check("error_no_we", weCount - weBefore, 0);
    applyStimulus(1'b0, 2'b10, 1'b0, 32'(4 * MEM_WORDS - 4), 32'h0, 32'h0, 1'b0, 2);
    expQ[expQ.size() - 1].data = mem[MEM_WORDS - 1];
    checkOutput("load_last_word", 0);

    // Misaligned word load, held off by the consumer for five cycles.
`ifdef MISALIGN_TRAP_EN
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h6, 32'h0, 32'h0, 1'b1, 1);
`else
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h6, 32'h0, 32'hA5A58006, 1'b0, 2);
`endif
    checkOutput("load_word_misaligned_6", 5);
    check("final_mem1", mem[1], 32'hA5A58006);

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
    $finish;
  end

endmodule
